// File: rtl/symbol_packer_pkg.sv
// symbol_packer_pkg
//   Shared modulation constants and helpers for the symbol packer and its
//   neighbours (constellation lookup table loader, framer).
//   MOD_* values are bits-per-symbol codes carried on mod_bits.
package symbol_packer_pkg;

  localparam int MOD_QPSK   = 2;
  localparam int MOD_8PSK   = 3;
  localparam int MOD_16APSK = 4;
  localparam int MOD_32APSK = 5;

  // Map a requested bits-per-symbol code into the supported range [1, max_bps].
  function automatic logic [2:0] clamp_bps(input logic [2:0] mod, input int unsigned max_bps);
    if (mod == 3'd0) return 3'd1;
    if (32'(mod) > max_bps) return 3'(max_bps);
    return mod;
  endfunction

endpackage

// File: rtl/symbol_packer.sv
// symbol_packer
//   Repacks a byte-wide AXI-Stream bitstream into bps-bit symbol indices,
//   MSB first, zero-extended to ADDRESS_WIDTH, feeding the constellation
//   lookup table address stream. bps is chosen per frame from mod_bits.
// Ports
//   aclk            clock for all buses
//   aresetn         asynchronous active-low reset
//   mod_bits        requested bits per symbol, sampled only between frames
//   data_in_*       byte stream in (tdata MSB transmitted first, tlast = last byte)
//   data_out_*      symbol stream out ({zeros, symbol}, tlast = last symbol)
module symbol_packer
  import symbol_packer_pkg::*;
#(
  parameter int IN_WIDTH      = 8,
  parameter int ADDRESS_WIDTH = 8,
  parameter int MAX_BPS       = 5
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic [2:0]               mod_bits,
  output logic                     data_in_tready,
  input  logic [IN_WIDTH-1:0]      data_in_tdata,
  input  logic                     data_in_tlast,
  input  logic                     data_in_tvalid,
  input  logic                     data_out_tready,
  output logic [ADDRESS_WIDTH-1:0] data_out_tdata,
  output logic                     data_out_tlast,
  output logic                     data_out_tvalid
);

  // Worst case residue is bps-1 bits plus one freshly appended byte.
  localparam int ACC_W = IN_WIDTH + MAX_BPS - 1;
  localparam int CNT_W = $clog2(ACC_W + 1);

  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic             last_pend;
  logic [2:0]       bps;

  logic [CNT_W-1:0] bps_c;
  logic [CNT_W-1:0] shift_amt;
  logic [CNT_W-1:0] cnt_rem;
  logic [CNT_W-1:0] top_shift;
  logic [ACC_W-1:0] acc_shift;
  logic [ACC_W-1:0] byte_ins;
  logic [MAX_BPS-1:0] sym;
  logic             in_fire;
  logic             out_fire;

  assign bps_c = CNT_W'(bps);

  // Output side depends on registered state only.
  assign data_out_tvalid = (cnt >= bps_c) || (last_pend && (cnt != '0));
  assign data_out_tlast  = last_pend && (cnt <= bps_c);

  // acc is left-aligned with zeros below the valid bits, so a short final
  // symbol comes out padded with zeros in its LSBs automatically.
  assign top_shift      = CNT_W'(ACC_W) - bps_c;
  assign sym            = MAX_BPS'(acc >> top_shift);
  assign data_out_tdata = ADDRESS_WIDTH'(sym);

  assign out_fire = data_out_tvalid && data_out_tready;

  // Bits left after this cycle's output shift decide whether a byte fits.
  // Looking through out_fire lets a byte land on the same edge the last
  // whole symbol drains, keeping one symbol per clock.
  assign shift_amt      = out_fire ? bps_c : '0;
  assign cnt_rem        = cnt - shift_amt;
  assign data_in_tready = !last_pend && (cnt_rem < bps_c);
  assign in_fire        = data_in_tvalid && data_in_tready;

  // New byte goes directly beneath the bits surviving the output shift.
  assign acc_shift = acc << shift_amt;
  assign byte_ins  = {data_in_tdata, {(MAX_BPS-1){1'b0}}} >> cnt_rem;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      acc       <= '0;
      cnt       <= '0;
      last_pend <= 1'b0;
      bps       <= 3'(MOD_QPSK);
    end else begin
      if (out_fire && data_out_tlast) begin
        // Frame done: drop any padding and return to idle.
        acc       <= '0;
        cnt       <= '0;
        last_pend <= 1'b0;
      end else if (in_fire) begin
        acc <= acc_shift | byte_ins;
        cnt <= cnt_rem + CNT_W'(IN_WIDTH);
        if (data_in_tlast) last_pend <= 1'b1;
      end else if (out_fire) begin
        acc <= acc_shift;
        cnt <= cnt_rem;
      end
      // Symbol width only changes while nothing is buffered.
      if ((cnt == '0) && !last_pend) bps <= clamp_bps(mod_bits, MAX_BPS);
    end
  end

endmodule

// File: tb/tb_symbol_packer.sv
module tb_symbol_packer;
  import symbol_packer_pkg::*;

  logic       aclk = 1'b0;
  logic       aresetn = 1'b0;
  logic [2:0] mod_bits = 3'd2;
  logic       data_in_tready;
  logic [7:0] data_in_tdata = 8'h00;
  logic       data_in_tlast = 1'b0;
  logic       data_in_tvalid = 1'b0;
  logic       data_out_tready = 1'b0;
  logic [7:0] data_out_tdata;
  logic       data_out_tlast;
  logic       data_out_tvalid;

  always #5 aclk = ~aclk;

  symbol_packer #(.IN_WIDTH(8), .ADDRESS_WIDTH(8), .MAX_BPS(5)) dut (
    .aclk(aclk), .aresetn(aresetn), .mod_bits(mod_bits),
    .data_in_tready(data_in_tready), .data_in_tdata(data_in_tdata),
    .data_in_tlast(data_in_tlast), .data_in_tvalid(data_in_tvalid),
    .data_out_tready(data_out_tready), .data_out_tdata(data_out_tdata),
    .data_out_tlast(data_out_tlast), .data_out_tvalid(data_out_tvalid)
  );

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  bit rnd_rdy = 1'b0;
  logic [8:0] got[$];
  int         got_cyc[$];
  logic [8:0] exp_q[$];
  logic [7:0] tx_q[$];
  logic       prev_stall = 1'b0;
  logic [8:0] prev_out = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(posedge aclk) cyc++;

  // Output monitor: capture every symbol transfer and check stall stability.
  always @(negedge aclk) begin
    if (prev_stall && aresetn) begin
      chk("hold_valid", {31'd0, data_out_tvalid}, 32'd1);
      chk("hold_data", {23'd0, data_out_tlast, data_out_tdata}, {23'd0, prev_out});
    end
    prev_stall = aresetn && data_out_tvalid && !data_out_tready;
    prev_out = {data_out_tlast, data_out_tdata};
    if (aresetn && data_out_tvalid && data_out_tready) begin
      got.push_back({data_out_tlast, data_out_tdata});
      got_cyc.push_back(cyc);
    end
  end

  initial begin
    forever begin
      @(posedge aclk); #1;
      if (rnd_rdy) data_out_tready = ($urandom_range(0, 3) != 0);
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send_byte(input logic [7:0] b, input logic l);
    int n = 0;
    data_in_tdata = b; data_in_tlast = l; data_in_tvalid = 1'b1;
    @(negedge aclk);
    while (!data_in_tready && n < 300) begin @(negedge aclk); n++; end
    if (n >= 300) chk("in_accept_timeout", 32'(n), 32'd0);
    @(posedge aclk); #1;
    data_in_tvalid = 1'b0; data_in_tlast = 1'b0;
  endtask

  task automatic send_tx(input int gap_max);
    for (int i = 0; i < tx_q.size(); i++) begin
      if (gap_max > 0) repeat ($urandom_range(0, gap_max)) begin @(posedge aclk); #1; end
      send_byte(tx_q[i], i == tx_q.size() - 1);
    end
  endtask

  task automatic wait_syms(input string name, input int n, input int limit);
    int t = 0;
    while (got.size() < n && t < limit) begin @(negedge aclk); #1; t++; end
    repeat (3) begin @(negedge aclk); #1; end
    chk($sformatf("%s_count", name), 32'(got.size()), 32'(n));
  endtask

  // Reference: concatenate frame bits MSB first, cut into bps-bit chunks,
  // zero-pad the final chunk, tlast on the final chunk.
  task automatic model_frame(input int mod);
    int bps;
    bit bits[$];
    int nsym;
    bps = (mod < 1) ? 1 : ((mod > 5) ? 5 : mod);
    foreach (tx_q[i]) for (int k = 7; k >= 0; k--) bits.push_back(tx_q[i][k]);
    nsym = (bits.size() + bps - 1) / bps;
    for (int s = 0; s < nsym; s++) begin
      int val = 0;
      for (int k = 0; k < bps; k++) begin
        int idx = s * bps + k;
        val = val * 2 + ((idx < bits.size()) ? int'(bits[idx]) : 0);
      end
      exp_q.push_back({s == nsym - 1, 8'(val)});
    end
  endtask

  task automatic cmp_list(input string name, input logic [0:11][7:0] syms, input int ns);
    for (int i = 0; i < ns && i < got.size(); i++) begin
      chk($sformatf("%s_sym%0d", name, i), {24'd0, got[i][7:0]}, {24'd0, syms[i]});
      chk($sformatf("%s_last%0d", name, i), {31'd0, got[i][8]}, {31'd0, (i == ns - 1)});
    end
  endtask

  typedef struct {
    int              mod;
    int              nb;
    logic [0:2][7:0] b;
    int              ns;
    logic [0:11][7:0] s;
  } vec_t;

  vec_t vecs[7];

  initial begin
    vecs[0] = '{MOD_QPSK,   1, {8'hB4, 8'h00, 8'h00}, 4, {8'd2, 8'd3, 8'd1, 8'd0, 64'd0}};
    vecs[1] = '{MOD_8PSK,   3, {8'hFF, 8'h00, 8'hAA}, 8, {8'd7, 8'd7, 8'd6, 8'd0, 8'd0, 8'd2, 8'd5, 8'd2, 32'd0}};
    vecs[2] = '{MOD_8PSK,   1, {8'hA5, 8'h00, 8'h00}, 3, {8'd5, 8'd1, 8'd2, 72'd0}};
    vecs[3] = '{MOD_16APSK, 1, {8'h3C, 8'h00, 8'h00}, 2, {8'd3, 8'd12, 80'd0}};
    vecs[4] = '{MOD_32APSK, 2, {8'hC3, 8'h5A, 8'h00}, 4, {8'd24, 8'd13, 8'd13, 8'd0, 64'd0}};
    vecs[5] = '{0,          1, {8'h96, 8'h00, 8'h00}, 8, {8'd1, 8'd0, 8'd0, 8'd1, 8'd0, 8'd1, 8'd1, 8'd0, 32'd0}};
    vecs[6] = '{7,          1, {8'hFF, 8'h00, 8'h00}, 2, {8'd31, 8'd28, 80'd0}};

    // Reset state
    repeat (3) @(negedge aclk);
    chk("rst_tvalid", {31'd0, data_out_tvalid}, 32'd0);
    chk("rst_tlast", {31'd0, data_out_tlast}, 32'd0);
    chk("rst_tdata", {24'd0, data_out_tdata}, 32'd0);
    aresetn = 1'b1;
    @(posedge aclk); #1;
    chk("post_rst_tvalid", {31'd0, data_out_tvalid}, 32'd0);

    // QPSK single byte: latency and input held off until drained
    mod_bits = 3'(MOD_QPSK); data_out_tready = 1'b1;
    repeat (2) begin @(posedge aclk); #1; end
    got.delete(); got_cyc.delete();
    send_byte(8'hB4, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge aclk); #1;
      if (i == 0) chk("t1_latency_tvalid", {31'd0, data_out_tvalid}, 32'd1);
      chk($sformatf("t1_in_tready_c%0d", i), {31'd0, data_in_tready}, 32'd0);
    end
    @(negedge aclk); #1;
    chk("t1_drained_tvalid", {31'd0, data_out_tvalid}, 32'd0);
    chk("t1_drained_in_tready", {31'd0, data_in_tready}, 32'd1);
    chk("t1_count", 32'(got.size()), 32'd4);
    cmp_list("t1", {8'd2, 8'd3, 8'd1, 8'd0, 64'd0}, 4);

    // Table of frames with tready held high: values plus back-to-back timing
    foreach (vecs[v]) begin
      @(posedge aclk); #1;
      mod_bits = 3'(vecs[v].mod);
      data_out_tready = 1'b1;
      got.delete(); got_cyc.delete(); tx_q.delete();
      for (int i = 0; i < vecs[v].nb; i++) tx_q.push_back(vecs[v].b[i]);
      send_tx(0);
      wait_syms($sformatf("vec%0d", v), vecs[v].ns, 200);
      cmp_list($sformatf("vec%0d", v), vecs[v].s, vecs[v].ns);
      if (got_cyc.size() == vecs[v].ns)
        chk($sformatf("vec%0d_nobubble", v), 32'(got_cyc[vecs[v].ns-1] - got_cyc[0]), 32'(vecs[v].ns - 1));
    end

    // Backpressure mid-frame
    @(posedge aclk); #1;
    mod_bits = 3'(MOD_QPSK); data_out_tready = 1'b0;
    got.delete(); got_cyc.delete(); tx_q.delete();
    tx_q.push_back(8'h6C); tx_q.push_back(8'h93);
    fork
      send_tx(0);
      begin
        int t = 0;
        logic [8:0] held;
        while (!data_out_tvalid && t < 50) begin @(negedge aclk); #1; t++; end
        @(posedge aclk); #1; data_out_tready = 1'b1;
        @(posedge aclk); #1; data_out_tready = 1'b0;
        @(negedge aclk); #1;
        held = {data_out_tlast, data_out_tdata};
        for (int i = 0; i < 5; i++) begin
          chk($sformatf("bp_tvalid_c%0d", i), {31'd0, data_out_tvalid}, 32'd1);
          chk($sformatf("bp_data_c%0d", i), {23'd0, data_out_tlast, data_out_tdata}, {23'd0, held});
          chk($sformatf("bp_in_tready_c%0d", i), {31'd0, data_in_tready}, 32'd0);
          @(negedge aclk); #1;
        end
        @(posedge aclk); #1; data_out_tready = 1'b1;
      end
    join
    wait_syms("bp", 8, 200);
    cmp_list("bp", {8'd1, 8'd2, 8'd3, 8'd0, 8'd2, 8'd1, 8'd0, 8'd3, 32'd0}, 8);

    // mod_bits change mid-frame is ignored until the next frame
    @(posedge aclk); #1;
    mod_bits = 3'(MOD_QPSK); data_out_tready = 1'b1;
    got.delete(); got_cyc.delete();
    send_byte(8'h1B, 1'b0);
    mod_bits = 3'(MOD_16APSK);
    send_byte(8'hE4, 1'b0);
    send_byte(8'h27, 1'b1);
    wait_syms("modsw", 12, 200);
    cmp_list("modsw", {8'd0, 8'd1, 8'd2, 8'd3, 8'd3, 8'd2, 8'd1, 8'd0, 8'd0, 8'd2, 8'd1, 8'd3}, 12);
    got.delete(); got_cyc.delete();
    @(posedge aclk); #1;
    send_byte(8'h3C, 1'b1);
    wait_syms("modsw_next", 2, 200);
    cmp_list("modsw_next", {8'd3, 8'd12, 80'd0}, 2);

    // Asynchronous reset mid-frame
    @(posedge aclk); #1;
    mod_bits = 3'(MOD_QPSK); data_out_tready = 1'b1;
    send_byte(8'hFF, 1'b0);
    @(negedge aclk); #1;
    chk("arst_pre_tvalid", {31'd0, data_out_tvalid}, 32'd1);
    #1 aresetn = 1'b0;
    #1;
    chk("arst_tvalid", {31'd0, data_out_tvalid}, 32'd0);
    chk("arst_tdata", {24'd0, data_out_tdata}, 32'd0);
    chk("arst_tlast", {31'd0, data_out_tlast}, 32'd0);
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
    @(posedge aclk); #1;
    got.delete(); got_cyc.delete();
    send_byte(8'hB4, 1'b1);
    wait_syms("arst_after", 4, 200);
    cmp_list("arst_after", {8'd2, 8'd3, 8'd1, 8'd0, 64'd0}, 4);

    // Randomized frames against the reference model
    got.delete(); got_cyc.delete(); exp_q.delete();
    rnd_rdy = 1'b1;
    for (int f = 0; f < 40; f++) begin
      int mod = $urandom_range(0, 7);
      int nb = $urandom_range(1, 5);
      @(posedge aclk); #1;
      mod_bits = 3'(mod);
      tx_q.delete();
      for (int i = 0; i < nb; i++) tx_q.push_back(8'($urandom_range(0, 255)));
      model_frame(mod);
      send_tx(2);
    end
    wait_syms("rand", exp_q.size(), 5000);
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      chk($sformatf("rand_sym%0d", i), {23'd0, got[i]}, {23'd0, exp_q[i]});
    rnd_rdy = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
